// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: select codes, FSM states, flag bundle.
// Pure types and constants; no logic.
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic sign;
    logic parity;
    logic overflow;
    logic div_by_zero;
  } alu_flags_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Unsigned WIDTH-step shift-add multiplier / restoring divider on operand magnitudes.
// Loads on start_i; done_o is high during the last step, with result_o showing that step's outcome.
module alu_iter_muldiv #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   a_mag_i,
  input  logic [WIDTH-1:0]   b_mag_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic               busy_q;
  logic               is_div_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   dvs_q;

  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     trial_diff;
  logic               trial_ge;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   quo_d;

  always_comb begin
    acc_d      = acc_q + (mplier_q[0] ? mcand_q : '0);
    // quo_q doubles as the dividend shift register; quotient bits enter from the bottom
    trial      = {rem_q, quo_q[WIDTH-1]};
    trial_diff = trial - {1'b0, dvs_q};
    trial_ge   = (trial >= {1'b0, dvs_q});
    rem_d      = trial_ge ? trial_diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_d      = {quo_q[WIDTH-2:0], trial_ge};
    result_o   = is_div_q ? {{WIDTH{1'b0}}, quo_d} : acc_d;
    done_o     = busy_q && (cnt_q == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      is_div_q <= is_div_i;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a_mag_i};
      mplier_q <= b_mag_i;
      rem_q    <= '0;
      quo_q    <= a_mag_i;
      dvs_q    <= b_mag_i;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked signed ALU: add/sub respond 1 cycle after accept, mul/div WIDTH+1 (div by zero 2).
// Accepts only in IDLE; the registered response is held until rsp_ready.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       select,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             carry,
  output logic             sign,
  output logic             parity,
  output logic             overflow,
  output logic             div_by_zero
);

  alu_state_e       state_q;
  logic [1:0]       op_q;
  logic             neg_q;
  logic             dbz_q;
  logic [WIDTH-1:0] out_q;
  alu_flags_t       flags_q;

  logic               accept;
  logic               a_neg;
  logic               b_neg;
  logic               b_zero;
  logic               is_md;
  logic               md_start;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               md_done;
  logic [2*WIDTH-1:0] md_result;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     dif_w;

  logic [WIDTH-1:0] res_out;
  logic             res_carry;
  logic             res_ovf;
  logic             res_dbz;
  logic             res_load;
  alu_flags_t       flags_d;

  assign accept   = (state_q == ST_IDLE) && req_valid;
  assign a_neg    = a[WIDTH-1];
  assign b_neg    = b[WIDTH-1];
  assign b_zero   = (b == '0);
  assign is_md    = select[1];
  assign md_start = accept && is_md && !((select == OP_DIV) && b_zero);
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;

  alu_iter_muldiv #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (md_start),
    .is_div_i (select == OP_DIV),
    .a_mag_i  (a_mag),
    .b_mag_i  (b_mag),
    .done_o   (md_done),
    .result_o (md_result)
  );

  always_comb begin
    sum_w     = {1'b0, a} + {1'b0, b};
    dif_w     = {1'b0, a} - {1'b0, b};
    prod_s    = neg_q ? -md_result : md_result;
    quo_s     = neg_q ? -md_result[WIDTH-1:0] : md_result[WIDTH-1:0];
    res_out   = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    res_dbz   = 1'b0;
    res_load  = 1'b0;
    if (accept && !is_md) begin
      res_load = 1'b1;
      if (select == OP_ADD) begin
        res_out   = sum_w[WIDTH-1:0];
        res_carry = sum_w[WIDTH];
        res_ovf   = (a_neg == b_neg) && (sum_w[WIDTH-1] != a_neg);
      end else begin
        res_out   = dif_w[WIDTH-1:0];
        res_carry = dif_w[WIDTH];
        res_ovf   = (a_neg != b_neg) && (dif_w[WIDTH-1] != a_neg);
      end
    end else if ((state_q == ST_EXEC) && dbz_q) begin
      res_load = 1'b1;
      res_dbz  = 1'b1;
    end else if ((state_q == ST_EXEC) && md_done) begin
      res_load = 1'b1;
      if (op_q == OP_MUL) begin
        res_out = prod_s[WIDTH-1:0];
        // product fits iff its top WIDTH+1 bits are all sign copies
        res_ovf = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
      end else begin
        res_out = quo_s;
        res_ovf = !neg_q && md_result[WIDTH-1];
      end
    end
    flags_d.zero        = (res_out == '0);
    flags_d.carry       = res_carry;
    flags_d.sign        = res_out[WIDTH-1];
    flags_d.parity      = ^res_out;
    flags_d.overflow    = res_ovf;
    flags_d.div_by_zero = res_dbz;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      neg_q   <= 1'b0;
      dbz_q   <= 1'b0;
      out_q   <= '0;
      flags_q <= '0;
    end else begin
      if (res_load) begin
        out_q   <= res_out;
        flags_q <= flags_d;
      end
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q    <= select;
            neg_q   <= a_neg ^ b_neg;
            dbz_q   <= (select == OP_DIV) && b_zero;
            state_q <= is_md ? ST_EXEC : ST_RESP;
          end
        end
        ST_EXEC: begin
          if (dbz_q || md_done) begin
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign out         = out_q;
  assign zero        = flags_q.zero;
  assign carry       = flags_q.carry;
  assign sign        = flags_q.sign;
  assign parity      = flags_q.parity;
  assign overflow    = flags_q.overflow;
  assign div_by_zero = flags_q.div_by_zero;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: an integer reference model predicts out, flags and latency.
module tb_alu_seq_unit;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic [1:0] select = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] out;
  logic       zero, carry, sign, parity, overflow, div_by_zero;

  alu_seq_unit #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .a           (a),
    .b           (b),
    .select      (select),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .out         (out),
    .zero        (zero),
    .carry       (carry),
    .sign        (sign),
    .parity      (parity),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] out;
    logic [5:0] flags;
    int         lat;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic logic [5:0] dut_flags();
    return {zero, carry, sign, parity, overflow, div_by_zero};
  endfunction

  // flags packed as {zero, carry, sign, parity, overflow, div_by_zero}
  function automatic exp_t model(input int av, input int bv, input logic [1:0] sel);
    exp_t       e;
    int         r;
    logic [3:0] o, ua, ub;
    logic       c, v, dz;
    ua = av[3:0];
    ub = bv[3:0];
    c = 1'b0;
    dz = 1'b0;
    e.lat = 1;
    case (sel)
      OP_ADD: begin r = av + bv; c = (int'(ua) + int'(ub)) > 15; end
      OP_SUB: begin r = av - bv; c = (ua < ub); end
      OP_MUL: begin r = av * bv; e.lat = 5; end
      default: begin
        if (bv == 0) begin r = 0; dz = 1'b1; e.lat = 2; end
        else begin r = av / bv; e.lat = 5; end
      end
    endcase
    v = (r > 7) || (r < -8) ? 1'b1 : 1'b0;
    if (sel == OP_DIV && bv == 0) v = 1'b0;
    o = r[3:0];
    e.out = o;
    e.flags = {(o == 4'd0), c, o[3], ^o, v, dz};
    return e;
  endfunction

  task automatic issue(input int av, input int bv, input logic [1:0] sel);
    @(negedge clk);
    a = av[3:0];
    b = bv[3:0];
    select = sel;
    req_valid = 1'b1;
    sbq.push_back(model(av, bv, sel));
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Waits (bounded) for a response, records it, then acknowledges it.
  task automatic get_rsp(output int lat, output logic [3:0] o, output logic [5:0] f,
                         output logic post_ok);
    lat = -1;
    o = 'x;
    f = 'x;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    o = out;
    f = dut_flags();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    post_ok = (rsp_valid === 1'b0) && (req_ready === 1'b1);
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (out !== 4'd0 || dut_flags() !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: out=%b flags=%b, required 0000 / 000000", out, dut_flags());
    end
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_handshake: rsp_valid=%b req_ready=%b, required 0 / 1", rsp_valid, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_addsub();
    int         ta[7] = '{7, 3, -8, -8, 5, 0, 6};
    int         tb[7] = '{1, 5, -1, 1, -3, 0, 7};
    logic [1:0] ts[7] = '{OP_ADD, OP_SUB, OP_ADD, OP_SUB, OP_ADD, OP_SUB, OP_ADD};
    exp_t       e;
    int         lat;
    logic [3:0] o;
    logic [5:0] f;
    logic       pok;
    for (int i = 0; i < 7; i++) begin
      issue(ta[i], tb[i], ts[i]);
      get_rsp(lat, o, f, pok);
      e = sbq.pop_front();
      n_checks++;
      if (lat !== e.lat) begin
        n_fail++;
        $display("FAIL addsub[%0d] latency: got %0d, required %0d", i, lat, e.lat);
      end
      n_checks++;
      if (o !== e.out || f !== e.flags) begin
        n_fail++;
        $display("FAIL addsub[%0d] %0d op%0d %0d: out=%b flags=%b, required %b / %b",
                 i, ta[i], ts[i], tb[i], o, f, e.out, e.flags);
      end
      n_checks++;
      if (!pok) begin
        n_fail++;
        $display("FAIL addsub[%0d] release: rsp_valid/req_ready wrong after ack, required 0/1", i);
      end
    end
  endtask

  task automatic test_muldiv();
    int         ta[10] = '{-3, -2, -8, 7, -7, -8, 5, 7, -8, 0};
    int         tb[10] = '{3, 3, -8, 7, 2, -1, 0, -2, 1, -3};
    logic [1:0] ts[10] = '{OP_MUL, OP_MUL, OP_MUL, OP_MUL, OP_DIV,
                           OP_DIV, OP_DIV, OP_DIV, OP_DIV, OP_DIV};
    exp_t       e;
    int         lat;
    logic [3:0] o;
    logic [5:0] f;
    logic       pok;
    for (int i = 0; i < 10; i++) begin
      issue(ta[i], tb[i], ts[i]);
      get_rsp(lat, o, f, pok);
      e = sbq.pop_front();
      n_checks++;
      if (lat !== e.lat) begin
        n_fail++;
        $display("FAIL muldiv[%0d] latency: got %0d, required %0d", i, lat, e.lat);
      end
      n_checks++;
      if (o !== e.out || f !== e.flags) begin
        n_fail++;
        $display("FAIL muldiv[%0d] %0d op%0d %0d: out=%b flags=%b, required %b / %b",
                 i, ta[i], ts[i], tb[i], o, f, e.out, e.flags);
      end
      n_checks++;
      if (!pok) begin
        n_fail++;
        $display("FAIL muldiv[%0d] release: rsp_valid/req_ready wrong after ack, required 0/1", i);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit   seen = 0;
    bit   stray = 0;
    issue(2, 2, OP_ADD);
    e = sbq.pop_front();
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (rsp_valid === 1'b1);
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL bp_response: rsp_valid never rose, required 1 within 20 cycles");
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      a = 4'(5 + i);
      b = 4'(3 - i);
      select = OP_MUL;
      n_checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || out !== e.out || dut_flags() !== e.flags) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: rsp_valid=%b req_ready=%b out=%b flags=%b, required 1/0/%b/%b",
                 i, rsp_valid, req_ready, out, dut_flags(), e.out, e.flags);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: rsp_valid=%b req_ready=%b, required 0 / 1", rsp_valid, req_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) stray = 1;
    end
    n_checks++;
    if (stray) begin
      n_fail++;
      $display("FAIL bp_ignored_request: rsp_valid=1 seen after release, required 0");
    end
  endtask

  task automatic test_reset_mid_op();
    exp_t       e;
    int         lat;
    logic [3:0] o;
    logic [5:0] f;
    logic       pok;
    issue(-7, 2, OP_DIV);
    void'(sbq.pop_back());
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out !== 4'd0 || dut_flags() !== 6'd0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_reset: out=%b flags=%b rsp_valid=%b req_ready=%b, required 0/0/0/1",
               out, dut_flags(), rsp_valid, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(1, 1, OP_ADD);
    get_rsp(lat, o, f, pok);
    e = sbq.pop_front();
    n_checks++;
    if (lat !== e.lat || o !== e.out || f !== e.flags) begin
      n_fail++;
      $display("FAIL midop_fresh: lat=%0d out=%b flags=%b, required %0d / %b / %b",
               lat, o, f, e.lat, e.out, e.flags);
    end
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    int         av, bv, lat;
    logic [1:0] s;
    logic [3:0] o;
    logic [5:0] f;
    logic       pok;
    for (int i = 0; i < 30; i++) begin
      av = int'($urandom_range(0, 15)) - 8;
      bv = int'($urandom_range(0, 15)) - 8;
      s = 2'($urandom_range(0, 3));
      issue(av, bv, s);
      get_rsp(lat, o, f, pok);
      e = sbq.pop_front();
      n_checks++;
      if (lat !== e.lat || o !== e.out || f !== e.flags || !pok) begin
        n_fail++;
        $display("FAIL b2b[%0d] %0d op%0d %0d: lat=%0d out=%b flags=%b rel=%b, required %0d / %b / %b / 1",
                 i, av, s, bv, lat, o, f, pok, e.lat, e.out, e.flags);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_muldiv();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
